// File: rtl/clk_div_ctrl.sv
// Run-time controller for the shared divide counter: accepts new divisors over a
// valid/ready handshake and applies them only at period boundaries.
module clk_div_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 32,
    parameter int unsigned MIN_DIV     = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] counter,
    output logic             clk_div_out,
    output logic             tick,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_div, w_div_n;
    logic [CNT_W-1:0] r_pend, w_pend_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic             r_out, w_out_n;

    logic             w_xfer;
    logic             w_last;
    logic [CNT_W-1:0] w_acc;

    assign cfg_ready   = (r_state != ST_PEND);
    assign running     = (r_state != ST_STOP);
    assign w_last      = (r_cnt == r_div - CNT_W'(1));
    assign tick        = running && w_last;
    assign counter     = r_cnt;
    assign clk_div_out = r_out;
    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_acc       = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;

    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_pend_n  = r_pend;
        w_cnt_n   = '0;
        unique case (r_state)
            ST_STOP: begin
                if (w_xfer) w_div_n = w_acc;
                if (enable) w_state_n = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) begin
                    if (w_xfer) w_div_n = w_acc;
                    w_state_n = enable ? ST_RUN : ST_STOP;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                    if (w_xfer) begin
                        w_pend_n  = w_acc;
                        w_state_n = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (w_last) begin
                    w_div_n   = r_pend;
                    w_state_n = enable ? ST_RUN : ST_STOP;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_n = ST_STOP;
        endcase
        // Output is computed from next-cycle values so it lines up with the counter.
        w_out_n = (w_state_n != ST_STOP) && (w_cnt_n >= (w_div_n >> 1));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
            r_div   <= CNT_W'(DEFAULT_DIV);
            r_pend  <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_pend  <= w_pend_n;
            r_cnt   <= w_cnt_n;
            r_out   <= w_out_n;
        end
    end

endmodule
